// File: rtl/aes_addroundkey_wddl.sv
// Column-serial WDDL AddRoundKey with a 128-bit dual-rail state buffer.
// Every evaluate phase is preceded by an enforced all-zero precharge phase.
module aes_addroundkey_wddl #(
    parameter int unsigned PRECHARGE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  col_mc,
    input  logic [31:0]  col_mc_n,
    input  logic [31:0]  key_col,
    input  logic [31:0]  key_col_n,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [1:0]   col_idx,
    output logic         precharge,
    output logic [127:0] state_p,
    output logic [127:0] state_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         dr_err
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned N_COLS  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST = 2'(N_COLS - 1);

    typedef enum logic [1:0] {
        S_PRE  = 2'd0,
        S_EVAL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   idx_d;
    logic                         err_d;
    logic [0:N_COLS-1][COL_W-1:0] stor_p_q, stor_p_d;
    logic [0:N_COLS-1][COL_W-1:0] stor_n_q, stor_n_d;
    logic [COL_W-1:0]             res_p_c, res_n_c;
    logic                         cw_ok_c;

    // WDDL XOR built only from AND/OR of the two rails; no inverters on data
    assign res_p_c = (col_mc & key_col_n) | (col_mc_n & key_col);
    assign res_n_c = (col_mc & key_col) | (col_mc_n & key_col_n);

    // Codeword is legal only when every bit pair is complementary
    assign cw_ok_c = (&(col_mc ^ col_mc_n)) & (&(key_col ^ key_col_n));

    // Next-state, counter, storage and error logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = col_idx;
        err_d    = dr_err;
        stor_p_d = stor_p_q;
        stor_n_d = stor_n_q;
        unique case (state_q)
            S_PRE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (in_valid) begin
                    state_d = S_PRE;
                    if (cw_ok_c) begin
                        stor_p_d[col_idx] = res_p_c;
                        stor_n_d[col_idx] = res_n_c;
                        if (col_idx == IDX_LAST) begin
                            state_d = S_FULL;
                        end else begin
                            idx_d = col_idx + 2'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    stor_p_d = '0;
                    stor_n_d = '0;
                    idx_d    = '0;
                    state_d  = S_PRE;
                end
            end
            default: state_d = S_PRE;
        endcase
    end

    // State registers; outputs are registered from the next-state decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_PRE;
            cnt_q     <= '0;
            col_idx   <= '0;
            stor_p_q  <= '0;
            stor_n_q  <= '0;
            dr_err    <= 1'b0;
            in_ready  <= 1'b0;
            precharge <= 1'b1;
            out_valid <= 1'b0;
            state_p   <= '0;
            state_n   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_idx   <= idx_d;
            stor_p_q  <= stor_p_d;
            stor_n_q  <= stor_n_d;
            dr_err    <= err_d;
            in_ready  <= (state_d == S_EVAL);
            precharge <= (state_d == S_PRE);
            out_valid <= (state_d == S_FULL);
            state_p   <= (state_d == S_FULL) ? stor_p_d : '0;
            state_n   <= (state_d == S_FULL) ? stor_n_d : '0;
        end
    end

endmodule
